pipe_stage_buf: RTL
===================

Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID … MEM/WB).
- Carries one opaque payload vector between two pipeline stages using a valid/ready handshake.
- An optional skid entry breaks the combinational ready path. Flush is built in, and the block provides occupancy plus stall and flush statistics.
- Instantiated once per stage boundary; the stage's concatenated control and data fields form in_data.

Parameters:
- DATA_W, 160, payload width in bits (≥1).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16, width of the statistics counters.
- RST_DATA, {DATA_W{1'b0}}, payload value on reset, on flush and on bubble output.

Ports:
- cpu_clk_50M  in  1  clock; all state changes on the rising edge.
- cpu_rst  in  1  reset; synchronous, active-high.
- flush  in  1  kills all held entries and any same-cycle input beat.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  payload; forced to RST_DATA whenever out_valid=0.
- occupancy  out  2  number of held entries (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturates.
- flush_cnt  out  CNT_W  valid entries discarded by flush; saturates.

Behaviour:
- Handshake: a transfer occurs when valid and ready are both 1 in the same cycle.
- Latency: an accepted beat appears on out_data the next cycle. No bubbles are inserted under continuous flow.
- State (SKID=1): EMPTY, FULL, SKIDFULL. Registers: main_q and skid_q (DATA_W each).
  - EMPTY: in_valid → FULL, main_q<=in_data.
  - FULL:
    - out_ready & in_valid → FULL, main_q<=in_data.
    - out_ready & !in_valid → EMPTY.
    - !out_ready & in_valid → SKIDFULL, skid_q<=in_data.
    - !out_ready & !in_valid → hold.
  - SKIDFULL: out_ready → FULL, main_q<=skid_q, skid_q<=RST_DATA; else hold.
  - in_ready = (state!=SKIDFULL). It is a function of registered state only, with no path from out_ready.
- SKID=0: states EMPTY and FULL only.
  - in_ready = (state==EMPTY) | out_ready, a combinational path.
  - skid_q is not built.
- out_valid = (state!=EMPTY). out_data = main_q when valid, else RST_DATA.
- occupancy: EMPTY=0, FULL=1, SKIDFULL=2.
- Flush (priority below reset, above everything else):
  - Next state EMPTY; main_q and skid_q <= RST_DATA.
  - A same-cycle in beat is dropped even if in_ready=1.
  - A same-cycle out transfer still counts as delivered downstream.
  - flush_cnt += occupancy, minus 1 if an out transfer completed that cycle (saturating add).
- stall_cnt: increments each cycle out_valid & !out_ready, including flush cycles. Saturates at all-ones.
- Reset (cpu_rst=1 at edge):
  - state EMPTY, main_q/skid_q=RST_DATA, both counters 0.
  - Outputs after reset: out_valid=0, out_data=RST_DATA, in_ready=1, occupancy=0.
  - Reset mid-transfer discards all entries and does not update the counters.
- Order is preserved and there is no duplication or loss, except on flush or reset.
- in_valid while in_ready=0: the beat is not consumed; upstream holds it (upstream contract, checked by assertion).

Decomposition:
- Shared package pipe_pkg:
  - state encoding constants PS_EMPTY=2'd0, PS_FULL=2'd1, PS_SKIDFULL=2'd2.
  - a saturating-increment function.
  - per-stage payload width constants (e.g. MEMWB_W).
- One natural sub-module: sat_counter (CNT_W, inc amount 0..2, sync clear). It is instantiated twice.

Test Plan:
- Reset then idle → out_valid=0, out_data=0, in_ready=1, occupancy=0, counters 0.
- Stream 8 beats 0x1..0x8 with out_ready=1 → out_data shows 0x1..0x8 one cycle later each; no gaps; stall_cnt=0.
- SKID=1: send 0xA, 0xB with out_ready=0 for 3 cycles → occupancy=2, in_ready=0, stall_cnt=3; release → 0xA then 0xB out, in order.
- SKID=0: hold out_ready=0 with FULL and in_valid=1 → in_ready=0, main_q unchanged; out_ready=1 same cycle → in_ready=1, replacement next cycle.
- SKIDFULL + flush with in_valid=1, out_ready=0 → next cycle EMPTY, out_data=RST_DATA, flush_cnt=2, the input beat is not delivered.
- Force stall_cnt to 2^CNT_W−1 (CNT_W=4, 20 stall cycles) → value holds at 15; cpu_rst mid-stall → counters 0, state EMPTY.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the inter-stage pipeline buffers.
//   - State encoding for pipe_stage_buf. The encoding equals the number of
//     held entries, so occupancy can be read straight off the state.
//   - Per-stage payload widths. These are the concatenated control and data
//     fields that each stage boundary carries.
//   - sat_add: a saturating add of a small amount (0..3) to a counter of up to
//     32 bits. The caller supplies the all-ones value for its counter width.
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef logic [1:0] ps_state_t;

    localparam ps_state_t PS_EMPTY    = 2'd0;
    localparam ps_state_t PS_FULL     = 2'd1;
    localparam ps_state_t PS_SKIDFULL = 2'd2;

    // Payload widths of the classic five-stage boundaries.
    localparam int IFID_W  = 64;
    localparam int IDEX_W  = 160;
    localparam int EXMEM_W = 110;
    localparam int MEMWB_W = 72;

    // Counter widths up to 32 bits are supported. The result never exceeds
    // max_val.
    function automatic logic [31:0] sat_add(
        input logic [31:0] value,
        input logic [1:0]  inc,
        input logic [31:0] max_val
    );
        logic [32:0] sum;
        sum = {1'b0, value} + {31'd0, inc};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating statistics counter. On each rising edge it adds inc (0..2). It
// sticks at all-ones. A synchronous clear has priority over the add.
//   cpu_clk_50M  in   clock
//   clr          in   synchronous clear, active-high
//   inc          in   amount added this cycle
//   count        out  current count (CNT_W bits, CNT_W <= 32)
// -----------------------------------------------------------------------------
module sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             cpu_clk_50M,
    input  logic             clr,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [31:0] MAX_VAL = 32'((64'd1 << CNT_W) - 64'd1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = CNT_W'(sat_add(32'(count_reg), inc, MAX_VAL));
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (clr) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
// Valid/ready pipeline register that sits between two pipeline stages. It
// carries one opaque payload. A beat that is accepted appears on out_data on
// the next cycle. The block inserts no bubbles while data flows continuously.
//
//   SKID=1 : two entries (main + skid). in_ready comes from registered state
//            only, so no combinational path runs from out_ready to in_ready.
//   SKID=0 : one entry. in_ready = empty | out_ready (combinational).
//
// Ports
//   cpu_clk_50M  in   clock
//   cpu_rst      in   synchronous active-high reset
//   flush        in   drops all held entries and any same-cycle input beat
//   in_valid     in   upstream beat valid
//   in_ready     out  beat accepted this cycle
//   in_data      in   upstream payload
//   out_valid    out  downstream beat valid
//   out_ready    in   downstream accepts this cycle
//   out_data     out  payload; RST_DATA whenever out_valid=0
//   occupancy    out  held entries (0..2)
//   stall_cnt    out  cycles with out_valid & !out_ready (saturating)
//   flush_cnt    out  valid entries discarded by flush (saturating)
// -----------------------------------------------------------------------------
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 160,
    parameter int                SKID     = 1,
    parameter int                CNT_W    = 16,
    parameter logic [DATA_W-1:0] RST_DATA = {DATA_W{1'b0}}
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    ps_state_t         state_reg;
    ps_state_t         state_next;
    logic [DATA_W-1:0] main_reg;
    logic [DATA_W-1:0] main_next;
    logic [DATA_W-1:0] skid_reg;
    logic              out_fire;

    // ------------------------------------------------------------------
    // State and main payload register
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state_reg <= PS_EMPTY;
            main_reg  <= RST_DATA;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and main payload
    // ------------------------------------------------------------------
    // The transitions below are keyed on in_valid. This is safe because
    // in_ready is 1 in every branch that loads in_data. For SKID=0 the
    // FULL & !out_ready case has in_ready=0 and holds the state.
    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        case (state_reg)
            PS_EMPTY: begin
                if (in_valid) begin
                    state_next = PS_FULL;
                    main_next  = in_data;
                end
            end
            PS_FULL: begin
                if (out_ready) begin
                    if (in_valid) begin
                        main_next = in_data;
                    end else begin
                        state_next = PS_EMPTY;
                    end
                end else if (in_valid && (SKID != 0)) begin
                    state_next = PS_SKIDFULL;
                end
            end
            PS_SKIDFULL: begin
                if (out_ready) begin
                    state_next = PS_FULL;
                    main_next  = skid_reg;
                end
            end
            default: begin
                state_next = PS_EMPTY;
                main_next  = RST_DATA;
            end
        endcase

        // Flush wins over every transfer. Only reset takes priority over it.
        if (flush) begin
            state_next = PS_EMPTY;
            main_next  = RST_DATA;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = (state_reg != PS_EMPTY);
        out_data  = (state_reg != PS_EMPTY) ? main_reg : RST_DATA;
        case (state_reg)
            PS_FULL:     occupancy = 2'd1;
            PS_SKIDFULL: occupancy = 2'd2;
            default:     occupancy = 2'd0;
        endcase
        if (SKID != 0) begin
            in_ready = (state_reg != PS_SKIDFULL);
        end else begin
            in_ready = (state_reg == PS_EMPTY) | out_ready;
        end
    end

    assign out_fire = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Skid entry. For SKID=0 it is a constant, so no flop is built and the
    // SKIDFULL branch above can never be reached.
    // ------------------------------------------------------------------
    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] skid_next;

            always_comb begin
                skid_next = skid_reg;
                if (flush) begin
                    skid_next = RST_DATA;
                end else if ((state_reg == PS_FULL) && !out_ready && in_valid) begin
                    skid_next = in_data;
                end else if ((state_reg == PS_SKIDFULL) && out_ready) begin
                    skid_next = RST_DATA;
                end
            end

            always_ff @(posedge cpu_clk_50M) begin
                if (cpu_rst) begin
                    skid_reg <= RST_DATA;
                end else begin
                    skid_reg <= skid_next;
                end
            end
        end else begin : g_no_skid
            assign skid_reg = RST_DATA;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Statistics: index 0 = stall cycles, index 1 = flushed entries.
    // A flush that completes an out transfer in the same cycle discards one
    // entry fewer, because the head entry was delivered.
    // ------------------------------------------------------------------
    logic [1:0]       cnt_inc [2];
    logic [CNT_W-1:0] cnt_val [2];

    always_comb begin
        cnt_inc[0] = {1'b0, out_valid & ~out_ready};
        cnt_inc[1] = flush ? (occupancy - {1'b0, out_fire}) : 2'd0;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .cpu_clk_50M (cpu_clk_50M),
                .clr         (cpu_rst),
                .inc         (cnt_inc[gi]),
                .count       (cnt_val[gi])
            );
        end
    endgenerate

    assign stall_cnt = cnt_val[0];
    assign flush_cnt = cnt_val[1];

    // Upstream contract: a beat that is refused must be held unchanged until
    // it is accepted. A flush or a reset releases it.
    upstream_hold_a : assert property (
        @(posedge cpu_clk_50M) disable iff (cpu_rst || flush)
        (in_valid && !in_ready) |=> (in_valid && $stable(in_data))
    );

endmodule
